// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampling baud generator, 2-flop rx synchronizer and a
// start/8 data (LSB first)/parity/stop framing FSM sampling each bit mid-point.
module uart_receiver #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [1:0] baud_select,
    input  logic       rx_in,
    output logic       baud_clk,
    output logic [7:0] data_out,
    output logic       parity_bit,
    output logic       data_ready,
    output logic       busy
);

    // Divisors are round(CLK_FREQ / (16 * baud)), done in integer arithmetic.
    localparam int DIV_2400  = (CLK_FREQ + 8 * 2400)  / (16 * 2400);
    localparam int DIV_4800  = (CLK_FREQ + 8 * 4800)  / (16 * 4800);
    localparam int DIV_9600  = (CLK_FREQ + 8 * 9600)  / (16 * 9600);
    localparam int DIV_19200 = (CLK_FREQ + 8 * 19200) / (16 * 19200);
    localparam int CNT_W     = $clog2(DIV_2400 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] div_m1;
    logic [1:0]       sel_q;

    logic rx_meta;
    logic rx_sync;

    state_t     state,      state_next;
    logic [3:0] tick_cnt,   tick_next;
    logic [2:0] bit_idx,    bit_next;
    logic [7:0] shift_reg,  shift_next;
    logic       parity_q,   par_next;
    logic [7:0] dout_next;
    logic       pbit_next;
    logic       ready_next;
    logic       busy_next;

    always_comb begin
        case (baud_select)
            2'b00:   div_m1 = CNT_W'(DIV_2400 - 1);
            2'b01:   div_m1 = CNT_W'(DIV_4800 - 1);
            2'b10:   div_m1 = CNT_W'(DIV_9600 - 1);
            default: div_m1 = CNT_W'(DIV_19200 - 1);
        endcase
    end

    // A rate change can leave the count past the new terminal value; restart
    // silently rather than wrapping through the full counter range.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            baud_cnt <= '0;
            baud_clk <= 1'b0;
            sel_q    <= 2'b00;
        end else begin
            sel_q <= baud_select;
            if (baud_select != sel_q && baud_cnt >= div_m1) begin
                baud_cnt <= '0;
                baud_clk <= 1'b0;
            end else if (baud_cnt == div_m1) begin
                baud_cnt <= '0;
                baud_clk <= 1'b1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
                baud_clk <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    // NOTE: every next-value is defaulted to its current value first, so no
    // path through the case leaves a signal unassigned and no latch appears.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        par_next   = parity_q;
        dout_next  = data_out;
        pbit_next  = parity_bit;
        ready_next = data_ready;
        busy_next  = busy;

        if (baud_clk) begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state_next = START;
                        tick_next  = '0;
                        busy_next  = 1'b1;
                        ready_next = 1'b0;
                    end
                end

                START: begin
                    if (tick_cnt == 4'd7) begin
                        tick_next = '0;
                        if (!rx_sync) begin
                            state_next = DATA;
                            bit_next   = '0;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                        end
                    end else begin
                        tick_next = tick_cnt + 4'd1;
                    end
                end

                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        tick_next           = '0;
                        shift_next[bit_idx] = rx_sync;
                        if (bit_idx == 3'd7) begin
                            state_next = PARITY;
                        end else begin
                            bit_next = bit_idx + 3'd1;
                        end
                    end else begin
                        tick_next = tick_cnt + 4'd1;
                    end
                end

                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        tick_next  = '0;
                        par_next   = rx_sync;
                        state_next = STOP;
                    end else begin
                        tick_next = tick_cnt + 4'd1;
                    end
                end

                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        tick_next  = '0;
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        // A low stop bit is a framing error: keep the old byte.
                        if (rx_sync) begin
                            dout_next  = shift_reg;
                            pbit_next  = parity_q;
                            ready_next = 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 4'd1;
                    end
                end

                default: begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register sees the values from before this edge.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_q   <= 1'b0;
            data_out   <= '0;
            parity_bit <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_next;
            bit_idx    <= bit_next;
            shift_reg  <= shift_next;
            parity_q   <= par_next;
            data_out   <= dout_next;
            parity_bit <= pbit_next;
            data_ready <= ready_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames are generated at the
// bit level and results compared against a frame-level expectation model.
module tb_uart_receiver;

    // Reduced clock frequency keeps whole frames short; 9600 baud rounds up here.
    localparam int CLK_FREQ = 5_000_000;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] baud_select = 2'b10;
    logic       rx_in   = 1'b1;
    logic       baud_clk;
    logic [7:0] data_out;
    logic       parity_bit;
    logic       data_ready;
    logic       busy;

    uart_receiver #(.CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .baud_select (baud_select),
        .rx_in       (rx_in),
        .baud_clk    (baud_clk),
        .data_out    (data_out),
        .parity_bit  (parity_bit),
        .data_ready  (data_ready),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level expectation of the receiver outputs.
    logic [7:0] exp_data  = 8'h00;
    logic       exp_par   = 1'b0;
    logic       exp_ready = 1'b0;

    function automatic int div_for(input logic [1:0] sel);
        real baud;
        case (sel)
            2'b00:   baud = 2400.0;
            2'b01:   baud = 4800.0;
            2'b10:   baud = 9600.0;
            default: baud = 19200.0;
        endcase
        return $rtoi(real'(CLK_FREQ) / (16.0 * baud) + 0.5);
    endfunction

    function automatic int bit_cycles();
        return 16 * div_for(baud_select);
    endfunction

    task automatic wait_tick(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge sys_clk);
            cycles++;
        end while (baud_clk !== 1'b1 && cycles < bound);
        if (baud_clk !== 1'b1) cycles = -1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (bit_cycles()) @(negedge sys_clk);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * bit_cycles()) @(negedge sys_clk);
    endtask

    task automatic send_tail(input logic [7:0] d, input logic par, input logic stop);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
        rx_in = 1'b1;
        if (stop) begin
            exp_data  = d;
            exp_par   = par;
            exp_ready = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_ready = 1'b0;
        drive_bit(1'b0);
        send_tail(d, par, stop);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_in = 1'b1;
        baud_select = 2'b10;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({baud_clk, data_out, parity_bit, data_ready, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {baud_clk, data_out, parity_bit, data_ready, busy});
        end
        reset = 1'b1;
        exp_data = 8'h00; exp_par = 1'b0; exp_ready = 1'b0;
        repeat (4) @(negedge sys_clk);
        n_tests++;
        if ({data_ready, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got ready/busy %b expected 00", {data_ready, busy});
        end
    endtask

    task automatic test_baud_rates();
        int c;
        for (int s = 0; s < 4; s++) begin
            baud_select = 2'(s);
            wait_tick(400, c);
            wait_tick(400, c);
            n_tests++;
            if (c != div_for(baud_select)) begin
                n_fail++;
                $display("FAIL baud_period_sel%0d: got %0d cycles expected %0d",
                         s, c, div_for(baud_select));
            end
        end
    endtask

    task automatic test_baud_switch();
        int c;
        baud_select = 2'b00;
        wait_tick(400, c);
        repeat (100) @(negedge sys_clk);
        // Count is at 100, above the new terminal value: restart, then a full period.
        baud_select = 2'b11;
        wait_tick(400, c);
        n_tests++;
        if (c != div_for(2'b11) + 1) begin
            n_fail++;
            $display("FAIL baud_switch_restart: got %0d cycles expected %0d", c, div_for(2'b11) + 1);
        end
    endtask

    task automatic test_9600();
        baud_select = 2'b10;
        idle_bits(2);
        exp_ready = 1'b0;
        drive_bit(1'b0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_busy_high: got %b expected 1", busy);
        end
        send_tail(8'hAB, 1'b1, 1'b1);
        n_tests++;
        if (data_out !== 8'hAB) begin n_fail++; $display("FAIL ab_data: got %h expected ab", data_out); end
        n_tests++;
        if (parity_bit !== 1'b1) begin n_fail++; $display("FAIL ab_parity: got %b expected 1", parity_bit); end
        n_tests++;
        if ({data_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL ab_ready_busy: got %b expected 10", {data_ready, busy});
        end
    endtask

    task automatic test_false_start();
        int n;
        bit seen;
        int c;
        baud_select = 2'b10;
        idle_bits(1);
        n = div_for(baud_select);
        exp_ready = 1'b0;
        seen = 1'b0;
        rx_in = 1'b0;
        for (int k = 0; k < 4 * n; k++) begin
            @(negedge sys_clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        rx_in = 1'b1;
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL false_start_busy_rise: got 0 expected 1"); end
        c = 0;
        while (busy !== 1'b0 && c < 12 * n) begin
            @(negedge sys_clk);
            c++;
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_fall: got %b expected 0", busy); end
        n_tests++;
        if (data_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL false_start_ready: got %b expected %b", data_ready, exp_ready);
        end
        n_tests++;
        if ({data_out, parity_bit} !== {exp_data, exp_par}) begin
            n_fail++;
            $display("FAIL false_start_hold: got %h/%b expected %h/%b", data_out, parity_bit, exp_data, exp_par);
        end
    endtask

    task automatic test_framing_error();
        baud_select = 2'b10;
        idle_bits(1);
        send_frame(8'h55, 1'($urandom), 1'b0);
        idle_bits(2);
        n_tests++;
        if (data_ready !== 1'b0) begin n_fail++; $display("FAIL framing_ready: got %b expected 0", data_ready); end
        n_tests++;
        if ({data_out, parity_bit} !== {exp_data, exp_par}) begin
            n_fail++;
            $display("FAIL framing_hold: got %h/%b expected %h/%b", data_out, parity_bit, exp_data, exp_par);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic p1, p2;
        p1 = 1'($urandom);
        p2 = 1'($urandom);
        baud_select = 2'b11;
        idle_bits(1);
        send_frame(8'h00, p1, 1'b1);
        n_tests++;
        if ({data_out, parity_bit, data_ready} !== {8'h00, p1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h/%b/%b expected 00/%b/1", data_out, parity_bit, data_ready, p1);
        end
        exp_ready = 1'b0;
        drive_bit(1'b0);
        n_tests++;
        if ({data_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_second_start: got ready/busy %b expected 01", {data_ready, busy});
        end
        send_tail(8'hFF, p2, 1'b1);
        n_tests++;
        if ({data_out, parity_bit, data_ready, busy} !== {exp_data, exp_par, exp_ready, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%b/%b/%b expected %h/%b/%b/0",
                     data_out, parity_bit, data_ready, busy, exp_data, exp_par, exp_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic       p;
        d = 8'($urandom);
        p = 1'($urandom);
        baud_select = 2'b11;
        idle_bits(1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx_in = d[3];
        repeat (bit_cycles() / 2) @(negedge sys_clk);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_tests++;
        if ({baud_clk, data_out, parity_bit, data_ready, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_frame_reset: got %h expected 000",
                     {baud_clk, data_out, parity_bit, data_ready, busy});
        end
        reset = 1'b1;
        exp_data = 8'h00; exp_par = 1'b0; exp_ready = 1'b0;
        idle_bits(2);
        n_tests++;
        if ({data_ready, busy, data_out} !== {2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_frame_abort: got %b/%b/%h expected 0/0/00", data_ready, busy, data_out);
        end
        send_frame(8'h3C, p, 1'b1);
        n_tests++;
        if ({data_out, parity_bit, data_ready, busy} !== {8'h3C, p, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_3c: got %h/%b/%b/%b expected 3c/%b/1/0",
                     data_out, parity_bit, data_ready, busy, p);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic       p;
        for (int f = 0; f < 4; f++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            baud_select = 2'($urandom_range(2, 3));
            idle_bits(1 + int'($urandom_range(0, 1)));
            send_frame(d, p, 1'b1);
            n_tests++;
            if ({data_out, parity_bit, data_ready, busy} !== {exp_data, exp_par, exp_ready, 1'b0}) begin
                n_fail++;
                $display("FAIL random_frame_%0d: got %h/%b/%b/%b expected %h/%b/%b/0",
                         f, data_out, parity_bit, data_ready, busy, exp_data, exp_par, exp_ready);
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_baud_rates();
        test_baud_switch();
        test_9600();
        test_false_start();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
